// File: rtl/multiport_cache_memory_if.sv
// Request/response bundle for the multiport cache array; all per-port
// buses are flattened with port p in slice [p*W +: W].
interface multiport_cache_memory_if #(
    parameter int STATUS_BITS    = 2,
    parameter int COHERENCE_BITS = 2,
    parameter int OFFSET_BITS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int NUMBER_OF_WAYS = 4,
    parameter int INDEX_BITS     = 8,
    parameter int ADDRESS_BITS   = 32,
    parameter int NUM_PORTS      = 2
);
    localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_BITS;
    localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS - INDEX_BITS;
    localparam int WAY_BITS    = $clog2(NUMBER_OF_WAYS);
    localparam int META_BITS   = STATUS_BITS + COHERENCE_BITS;

    logic [NUM_PORTS-1:0]                read;
    logic [NUM_PORTS-1:0]                write;
    logic [NUM_PORTS-1:0]                invalidate;
    logic [NUM_PORTS*INDEX_BITS-1:0]     index;
    logic [NUM_PORTS*TAG_BITS-1:0]       tag;
    logic [NUM_PORTS*META_BITS-1:0]      meta_data;
    logic [NUM_PORTS*BLOCK_WIDTH-1:0]    data_in;
    logic [NUM_PORTS*WAY_BITS-1:0]       way_select;
    logic [NUM_PORTS*BLOCK_WIDTH-1:0]    data_out;
    logic [NUM_PORTS*TAG_BITS-1:0]       tag_out;
    logic [NUM_PORTS*WAY_BITS-1:0]       matched_way;
    logic [NUM_PORTS*COHERENCE_BITS-1:0] coh_bits;
    logic [NUM_PORTS*STATUS_BITS-1:0]    status_bits;
    logic [NUM_PORTS-1:0]                hit;
    logic                                init_done;

    modport master (
        output read, write, invalidate, index, tag, meta_data, data_in, way_select,
        input  data_out, tag_out, matched_way, coh_bits, status_bits, hit, init_done
    );
    modport slave (
        input  read, write, invalidate, index, tag, meta_data, data_in, way_select,
        output data_out, tag_out, matched_way, coh_bits, status_bits, hit, init_done
    );
endinterface

// File: rtl/multiport_cache_memory.sv
// N-port set-associative cache array: tag/meta/data storage, hit detection,
// victim selection (true LRU or round-robin) and a post-reset clearing sweep.
module multiport_cache_memory #(
    parameter int STATUS_BITS      = 2,
    parameter int COHERENCE_BITS   = 2,
    parameter int OFFSET_BITS      = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_WAYS   = 4,
    parameter int INDEX_BITS       = 8,
    parameter int ADDRESS_BITS     = 32,
    parameter int NUM_PORTS        = 2,
    parameter int REPLACEMENT_MODE = 0
) (
    input logic clock,
    input logic reset,
    multiport_cache_memory_if.slave bus
);
    localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_BITS;
    localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS - INDEX_BITS;
    localparam int WAY_BITS    = $clog2(NUMBER_OF_WAYS);
    localparam int META_BITS   = STATUS_BITS + COHERENCE_BITS;
    localparam int CACHE_DEPTH = 1 << INDEX_BITS;
    localparam int VALID_BIT   = META_BITS - 1;

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]            state;
    logic [INDEX_BITS-1:0] counter;
    logic                  init_q;

    logic [BLOCK_WIDTH-1:0] data_mem [CACHE_DEPTH][NUMBER_OF_WAYS];
    logic [META_BITS-1:0]   meta_mem [CACHE_DEPTH][NUMBER_OF_WAYS];
    logic [TAG_BITS-1:0]    tag_mem  [CACHE_DEPTH][NUMBER_OF_WAYS];
    logic [WAY_BITS-1:0]    age_mem  [CACHE_DEPTH][NUMBER_OF_WAYS];
    logic [WAY_BITS-1:0]    rr_ptr   [CACHE_DEPTH];

    logic [INDEX_BITS-1:0]  p_idx  [NUM_PORTS];
    logic [TAG_BITS-1:0]    p_tag  [NUM_PORTS];
    logic [WAY_BITS-1:0]    p_way  [NUM_PORTS];
    logic [META_BITS-1:0]   p_meta [NUM_PORTS];
    logic [BLOCK_WIDTH-1:0] p_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]   hit_c, inv_found, upd, win;
    logic [WAY_BITS-1:0]    hit_way [NUM_PORTS];
    logic [WAY_BITS-1:0]    inv_way [NUM_PORTS];
    logic [WAY_BITS-1:0]    lru_way [NUM_PORTS];
    logic [WAY_BITS-1:0]    sel_way [NUM_PORTS];

    logic [BLOCK_WIDTH-1:0]    dout_q [NUM_PORTS];
    logic [TAG_BITS-1:0]       tout_q [NUM_PORTS];
    logic [WAY_BITS-1:0]       way_q  [NUM_PORTS];
    logic [META_BITS-1:0]      meta_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]      hit_q;

    logic                  rep_en, rep_write;
    logic [WAY_BITS-1:0]   rep_way;
    logic [INDEX_BITS-1:0] rep_idx;

    // Lookup runs on pre-edge contents, which gives old-data read-during-write.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            p_idx[p]     = bus.index[p*INDEX_BITS +: INDEX_BITS];
            p_tag[p]     = bus.tag[p*TAG_BITS +: TAG_BITS];
            p_way[p]     = bus.way_select[p*WAY_BITS +: WAY_BITS];
            p_meta[p]    = bus.meta_data[p*META_BITS +: META_BITS];
            p_data[p]    = bus.data_in[p*BLOCK_WIDTH +: BLOCK_WIDTH];
            hit_c[p]     = 1'b0;
            hit_way[p]   = '0;
            inv_found[p] = 1'b0;
            inv_way[p]   = '0;
            lru_way[p]   = '0;
            for (int w = NUMBER_OF_WAYS - 1; w >= 0; w--) begin
                if (meta_mem[p_idx[p]][w][VALID_BIT] && tag_mem[p_idx[p]][w] == p_tag[p]) begin
                    hit_c[p]   = 1'b1;
                    hit_way[p] = WAY_BITS'(w);
                end
                if (!meta_mem[p_idx[p]][w][VALID_BIT]) begin
                    inv_found[p] = 1'b1;
                    inv_way[p]   = WAY_BITS'(w);
                end
                if (age_mem[p_idx[p]][w] == WAY_BITS'(NUMBER_OF_WAYS - 1))
                    lru_way[p] = WAY_BITS'(w);
            end
            sel_way[p] = lru_way[p];
            if (hit_c[p])                   sel_way[p] = hit_way[p];
            else if (inv_found[p])          sel_way[p] = inv_way[p];
            else if (REPLACEMENT_MODE == 1) sel_way[p] = rr_ptr[p_idx[p]];
        end
    end

    // A port's update is dropped when any higher port targets the same entry.
    always_comb begin
        upd = '0;
        win = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            upd[p] = (state == READY) && (bus.write[p] || bus.invalidate[p]);
        for (int p = 0; p < NUM_PORTS; p++) begin
            win[p] = upd[p];
            for (int q = p + 1; q < NUM_PORTS; q++)
                if (upd[q] && p_idx[q] == p_idx[p] && p_way[q] == p_way[p])
                    win[p] = 1'b0;
        end
    end

    always_comb begin
        rep_en    = 1'b0;
        rep_write = 1'b0;
        rep_way   = hit_way[0];
        rep_idx   = p_idx[0];
        if (state == READY && bus.write[0] && !bus.invalidate[0]) begin
            rep_en    = 1'b1;
            rep_write = 1'b1;
            rep_way   = p_way[0];
        end else if (state == READY && bus.read[0] && hit_c[0]) begin
            rep_en = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= INIT;
            counter <= '0;
            init_q  <= 1'b0;
        end else if (state == INIT) begin
            counter <= counter + 1'b1;
            if (counter == INDEX_BITS'(CACHE_DEPTH - 1)) begin
                state  <= READY;
                init_q <= 1'b1;
            end
        end
    end

    // Array storage carries no reset; the sweep clears metadata set by set.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) begin
                for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
                    meta_mem[counter][w] <= '0;
                    tag_mem[counter][w]  <= '0;
                    age_mem[counter][w]  <= WAY_BITS'(w);
                end
                rr_ptr[counter] <= '0;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (win[p]) begin
                        if (bus.invalidate[p]) begin
                            meta_mem[p_idx[p]][p_way[p]] <= '0;
                            tag_mem[p_idx[p]][p_way[p]]  <= '0;
                        end else begin
                            data_mem[p_idx[p]][p_way[p]] <= p_data[p];
                            meta_mem[p_idx[p]][p_way[p]] <= p_meta[p];
                            tag_mem[p_idx[p]][p_way[p]]  <= p_tag[p];
                        end
                    end
                end
                if (rep_en && REPLACEMENT_MODE == 0) begin
                    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
                        if (WAY_BITS'(w) == rep_way)
                            age_mem[rep_idx][w] <= '0;
                        else if (age_mem[rep_idx][w] < age_mem[rep_idx][rep_way])
                            age_mem[rep_idx][w] <= age_mem[rep_idx][w] + 1'b1;
                    end
                end else if (rep_en && rep_write && rep_way == rr_ptr[rep_idx]) begin
                    rr_ptr[rep_idx] <= rr_ptr[rep_idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (reset) begin
                dout_q[p] <= '0;
                tout_q[p] <= '0;
                way_q[p]  <= '0;
                meta_q[p] <= '0;
                hit_q[p]  <= 1'b0;
            end else if (state == READY && bus.read[p]) begin
                dout_q[p] <= data_mem[p_idx[p]][sel_way[p]];
                tout_q[p] <= tag_mem[p_idx[p]][sel_way[p]];
                way_q[p]  <= sel_way[p];
                meta_q[p] <= meta_mem[p_idx[p]][sel_way[p]];
                hit_q[p]  <= hit_c[p];
            end
        end
    end

    always_comb begin
        bus.data_out    = '0;
        bus.tag_out     = '0;
        bus.matched_way = '0;
        bus.coh_bits    = '0;
        bus.status_bits = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.data_out[p*BLOCK_WIDTH +: BLOCK_WIDTH]        = dout_q[p];
            bus.tag_out[p*TAG_BITS +: TAG_BITS]               = tout_q[p];
            bus.matched_way[p*WAY_BITS +: WAY_BITS]           = way_q[p];
            bus.coh_bits[p*COHERENCE_BITS +: COHERENCE_BITS]  = meta_q[p][COHERENCE_BITS-1:0];
            bus.status_bits[p*STATUS_BITS +: STATUS_BITS]     = meta_q[p][META_BITS-1:COHERENCE_BITS];
        end
    end

    assign bus.hit       = hit_q;
    assign bus.init_done = init_q;
endmodule

// File: tb/tb_multiport_cache_memory.sv
// Bench for multiport_cache_memory: a 3-port LRU instance checked against a
// recency-list model, plus a 2-port round-robin instance for victim checks.
module tb_multiport_cache_memory;
    localparam int NP = 3, IB = 8, TB = 22, BW = 128, WB = 2, NW = 4, DEPTH = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multiport_cache_memory_if #(.NUM_PORTS(NP)) bus_a ();
    multiport_cache_memory_if #(.NUM_PORTS(2))  bus_b ();

    multiport_cache_memory #(.NUM_PORTS(NP), .REPLACEMENT_MODE(0)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a));
    multiport_cache_memory #(.NUM_PORTS(2), .REPLACEMENT_MODE(1)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    // Reference model: per-entry contents and a recency list per set (MRU first).
    bit [TB-1:0] m_tag  [DEPTH][NW];
    bit [1:0]    m_st   [DEPTH][NW];
    bit [1:0]    m_co   [DEPTH][NW];
    bit [BW-1:0] m_data [DEPTH][NW];
    bit          m_dk   [DEPTH][NW];
    int          m_order[DEPTH][NW];

    bit          o_rd[NP], o_wr[NP], o_inv[NP];
    int          o_idx[NP], o_way[NP];
    bit [TB-1:0] o_tag[NP];
    bit [3:0]    o_meta[NP];
    bit [BW-1:0] o_data[NP];

    bit          e_hit[NP], e_dk[NP];
    int          e_way[NP];
    bit [TB-1:0] e_tag[NP];
    bit [1:0]    e_st[NP], e_co[NP];
    bit [BW-1:0] e_data[NP];

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_model();
        for (int s = 0; s < DEPTH; s++)
            for (int w = 0; w < NW; w++) begin
                m_tag[s][w] = '0; m_st[s][w] = '0; m_co[s][w] = '0;
                m_dk[s][w] = 1'b0; m_order[s][w] = w;
            end
    endtask

    task automatic clear_ops();
        for (int p = 0; p < NP; p++) begin
            o_rd[p] = 0; o_wr[p] = 0; o_inv[p] = 0; o_idx[p] = 0; o_way[p] = 0;
            o_tag[p] = '0; o_meta[p] = '0; o_data[p] = '0;
        end
    endtask

    task automatic touch(int s, int w);
        int pos = 0;
        for (int k = 0; k < NW; k++) if (m_order[s][k] == w) pos = k;
        for (int k = pos; k > 0; k--) m_order[s][k] = m_order[s][k-1];
        m_order[s][0] = w;
    endtask

    task automatic predict(int p);
        int s = o_idx[p];
        int w = -1;
        for (int i = 0; i < NW; i++)
            if (w < 0 && m_st[s][i][1] && m_tag[s][i] == o_tag[p]) w = i;
        e_hit[p] = (w >= 0);
        for (int i = 0; i < NW; i++)
            if (w < 0 && !m_st[s][i][1]) w = i;
        if (w < 0) w = m_order[s][NW-1];
        e_way[p] = w; e_tag[p] = m_tag[s][w]; e_st[p] = m_st[s][w];
        e_co[p] = m_co[s][w]; e_data[p] = m_data[s][w]; e_dk[p] = m_dk[s][w];
    endtask

    task automatic apply_model();
        for (int p = 0; p < NP; p++) begin
            bit shadowed = 0;
            for (int q = p + 1; q < NP; q++)
                if ((o_wr[q] || o_inv[q]) && o_idx[q] == o_idx[p] && o_way[q] == o_way[p])
                    shadowed = 1;
            if (!shadowed && o_inv[p]) begin
                m_tag[o_idx[p]][o_way[p]] = '0;
                m_st[o_idx[p]][o_way[p]]  = '0;
                m_co[o_idx[p]][o_way[p]]  = '0;
            end else if (!shadowed && o_wr[p]) begin
                m_tag[o_idx[p]][o_way[p]]  = o_tag[p];
                m_st[o_idx[p]][o_way[p]]   = o_meta[p][3:2];
                m_co[o_idx[p]][o_way[p]]   = o_meta[p][1:0];
                m_data[o_idx[p]][o_way[p]] = o_data[p];
                m_dk[o_idx[p]][o_way[p]]   = 1'b1;
            end
        end
        if (o_wr[0] && !o_inv[0]) touch(o_idx[0], o_way[0]);
        else if (o_rd[0] && e_hit[0]) touch(o_idx[0], e_way[0]);
    endtask

    // Presents the staged ops for one edge, then idles one edge so read
    // results are sampled a full cycle after the request edge.
    task automatic step_a();
        for (int p = 0; p < NP; p++) if (o_rd[p]) predict(p);
        for (int p = 0; p < NP; p++) begin
            bus_a.read[p] = o_rd[p]; bus_a.write[p] = o_wr[p]; bus_a.invalidate[p] = o_inv[p];
            bus_a.index[p*IB +: IB]     = IB'(o_idx[p]);
            bus_a.way_select[p*WB +: WB] = WB'(o_way[p]);
            bus_a.tag[p*TB +: TB]       = o_tag[p];
            bus_a.meta_data[p*4 +: 4]   = o_meta[p];
            bus_a.data_in[p*BW +: BW]   = o_data[p];
        end
        cyc();
        apply_model();
        bus_a.read = '0; bus_a.write = '0; bus_a.invalidate = '0;
        cyc();
    endtask

    task automatic step_b(int p, bit rd, bit wr, int idx, bit [TB-1:0] tg, int way);
        bus_b.read[p] = rd; bus_b.write[p] = wr; bus_b.invalidate = '0;
        bus_b.index[p*IB +: IB] = IB'(idx);
        bus_b.tag[p*TB +: TB] = tg;
        bus_b.way_select[p*WB +: WB] = WB'(way);
        bus_b.meta_data[p*4 +: 4] = 4'b1000;
        bus_b.data_in[p*BW +: BW] = {4{32'(idx + way)}};
        cyc();
        bus_b.read = '0; bus_b.write = '0;
        cyc();
    endtask

    task automatic count_init(string name);
        int n = 0;
        while (bus_a.init_done !== 1'b1 && n < 1000) begin cyc(); n++; end
        checks++;
        if (n != DEPTH) begin
            errors++; $display("FAIL %s: init cycles got %0d want %0d", name, n, DEPTH);
        end
        checks++;
        if (bus_b.init_done !== 1'b1) begin
            errors++; $display("FAIL %s rr: init_done got %b want 1", name, bus_b.init_done);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) cyc();
        checks++;
        if (bus_a.init_done !== 1'b0 || bus_a.hit !== '0 || bus_a.matched_way !== '0 || bus_a.data_out !== '0) begin
            errors++; $display("FAIL reset outputs: init=%b hit=%b way=%h want zeros",
                               bus_a.init_done, bus_a.hit, bus_a.matched_way);
        end
        reset = 0;
        count_init("init sweep");
        reset = 1; cyc(); reset = 0;
        repeat (100) cyc();
        checks++;
        if (bus_a.init_done !== 1'b0) begin
            errors++; $display("FAIL mid sweep: init_done got %b want 0", bus_a.init_done);
        end
        reset = 1; cyc(); reset = 0;
        count_init("restarted sweep");
        reset_model();
    endtask

    task automatic test_post_init_read();
        clear_ops();
        for (int p = 0; p < NP; p++) begin o_rd[p] = 1; o_idx[p] = 5 + 100 * p; o_tag[p] = 22'h0; end
        step_a();
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (bus_a.hit[p] !== 1'b0 || bus_a.matched_way[p*WB +: WB] !== 2'd0 || bus_a.status_bits[p*2 +: 2] !== 2'b00) begin
                errors++; $display("FAIL post-init read p%0d: hit=%b way=%0d want 0/0",
                                   p, bus_a.hit[p], bus_a.matched_way[p*WB +: WB]);
            end
        end
    endtask

    task automatic test_write_read();
        clear_ops();
        o_wr[0] = 1; o_idx[0] = 1; o_way[0] = 2; o_tag[0] = 22'h1CCCCC; o_meta[0] = 4'b1011;
        o_data[0] = 128'h11555555_99999999_33777777_00001000;
        step_a();
        clear_ops();
        o_rd[1] = 1; o_idx[1] = 1; o_tag[1] = 22'h1CCCCC;
        step_a();
        checks++;
        if (bus_a.hit[1] !== 1'b1 || bus_a.matched_way[2*1 +: 2] !== 2'd2) begin
            errors++; $display("FAIL write/read hit: hit=%b way=%0d want 1/2", bus_a.hit[1], bus_a.matched_way[2 +: 2]);
        end
        checks++;
        if (bus_a.status_bits[2 +: 2] !== 2'b10 || bus_a.coh_bits[2 +: 2] !== 2'b11) begin
            errors++; $display("FAIL write/read meta: st=%b coh=%b want 10/11", bus_a.status_bits[2 +: 2], bus_a.coh_bits[2 +: 2]);
        end
        checks++;
        if (bus_a.data_out[BW +: BW] !== 128'h11555555_99999999_33777777_00001000) begin
            errors++; $display("FAIL write/read data: got %h", bus_a.data_out[BW +: BW]);
        end
    endtask

    task automatic test_lru_victim();
        for (int w = 0; w < NW; w++) begin
            clear_ops();
            o_wr[0] = 1; o_idx[0] = 1; o_way[0] = w; o_tag[0] = 22'h0AA000 + TB'(w);
            o_meta[0] = 4'b1000; o_data[0] = 128'(w + 64);
            step_a();
        end
        clear_ops(); o_rd[0] = 1; o_idx[0] = 1; o_tag[0] = 22'h0AA000;
        step_a();
        checks++;
        if (bus_a.hit[0] !== 1'b1 || bus_a.matched_way[0 +: 2] !== 2'd0) begin
            errors++; $display("FAIL lru hit way0: hit=%b way=%0d want 1/0", bus_a.hit[0], bus_a.matched_way[0 +: 2]);
        end
        for (int r = 0; r < 3; r++) begin
            clear_ops();
            if (r == 1) begin o_rd[1] = 1; o_idx[1] = 1; o_tag[1] = 22'h0AA001; end
            else begin o_rd[0] = 1; o_idx[0] = 1; o_tag[0] = 22'h2BB123; end
            step_a();
            checks++;
            if (bus_a.hit[r == 1 ? 1 : 0] !== (r == 1) || bus_a.matched_way[(r == 1 ? 2 : 0) +: 2] !== 2'd1) begin
                errors++; $display("FAIL lru victim step%0d: hit=%b way=%0d want %0b/1", r,
                                   bus_a.hit[r == 1 ? 1 : 0], bus_a.matched_way[(r == 1 ? 2 : 0) +: 2], r == 1);
            end
        end
    endtask

    task automatic test_invalidate();
        clear_ops(); o_inv[1] = 1; o_idx[1] = 1; o_way[1] = 1;
        step_a();
        clear_ops(); o_rd[1] = 1; o_idx[1] = 1; o_tag[1] = 22'h0AA001;
        step_a();
        checks++;
        if (bus_a.hit[1] !== 1'b0 || bus_a.matched_way[2 +: 2] !== 2'd1 || bus_a.status_bits[2 +: 2] !== 2'b00 ||
            bus_a.coh_bits[2 +: 2] !== 2'b00 || bus_a.tag_out[TB +: TB] !== '0) begin
            errors++; $display("FAIL invalidate: hit=%b way=%0d st=%b coh=%b tag=%h want 0/1/0/0/0", bus_a.hit[1],
                               bus_a.matched_way[2 +: 2], bus_a.status_bits[2 +: 2], bus_a.coh_bits[2 +: 2], bus_a.tag_out[TB +: TB]);
        end
        clear_ops(); o_rd[0] = 1; o_idx[0] = 1; o_tag[0] = 22'h0AA001;
        step_a();
        checks++;
        if (bus_a.hit[0] !== 1'b0 || bus_a.matched_way[0 +: 2] !== 2'd1) begin
            errors++; $display("FAIL invalid-way victim: hit=%b way=%0d want 0/1", bus_a.hit[0], bus_a.matched_way[0 +: 2]);
        end
    endtask

    task automatic test_multi_write();
        clear_ops();
        for (int p = 0; p < NP; p++) begin
            o_wr[p] = 1; o_idx[p] = 1; o_way[p] = 1; o_tag[p] = 22'h3AAA01 + TB'(p);
            o_data[p] = 128'(8'h03 + 8'(16 * p));
        end
        o_meta[0] = 4'b1001; o_meta[1] = 4'b1010; o_meta[2] = 4'b1111;
        step_a();
        clear_ops();
        o_rd[2] = 1; o_idx[2] = 1; o_tag[2] = 22'h3AAA03;
        o_rd[1] = 1; o_idx[1] = 1; o_tag[1] = 22'h0AA000;
        step_a();
        checks++;
        if (bus_a.hit[2] !== 1'b1 || bus_a.matched_way[4 +: 2] !== 2'd1 || bus_a.data_out[2*BW +: BW] !== 128'h23 ||
            bus_a.status_bits[4 +: 2] !== 2'b11 || bus_a.coh_bits[4 +: 2] !== 2'b11) begin
            errors++; $display("FAIL multi write: hit=%b way=%0d data=%h st=%b coh=%b want 1/1/23/11/11", bus_a.hit[2],
                               bus_a.matched_way[4 +: 2], bus_a.data_out[2*BW +: BW], bus_a.status_bits[4 +: 2], bus_a.coh_bits[4 +: 2]);
        end
        checks++;
        if (bus_a.hit[1] !== 1'b1 || bus_a.matched_way[2 +: 2] !== 2'd0 || bus_a.data_out[BW +: BW] !== 128'd64) begin
            errors++; $display("FAIL multi write other way: hit=%b way=%0d data=%h want 1/0/40", bus_a.hit[1],
                               bus_a.matched_way[2 +: 2], bus_a.data_out[BW +: BW]);
        end
    endtask

    task automatic test_back_to_back();
        clear_ops();
        o_wr[0] = 1; o_idx[0] = 3; o_tag[0] = 22'h155555; o_meta[0] = 4'b1000; o_data[0] = 128'hD1;
        step_a();
        clear_ops();
        o_wr[0] = 1; o_idx[0] = 3; o_tag[0] = 22'h155555; o_meta[0] = 4'b1101; o_data[0] = 128'hD2;
        o_rd[1] = 1; o_idx[1] = 3; o_tag[1] = 22'h155555;
        step_a();
        checks++;
        if (bus_a.hit[1] !== 1'b1 || bus_a.data_out[BW +: BW] !== 128'hD1 || bus_a.status_bits[2 +: 2] !== 2'b10) begin
            errors++; $display("FAIL read during write: hit=%b data=%h st=%b want 1/d1/10", bus_a.hit[1],
                               bus_a.data_out[BW +: BW], bus_a.status_bits[2 +: 2]);
        end
        clear_ops(); o_rd[2] = 1; o_idx[2] = 3; o_tag[2] = 22'h155555;
        step_a();
        checks++;
        if (bus_a.data_out[2*BW +: BW] !== 128'hD2 || bus_a.status_bits[4 +: 2] !== 2'b11 || bus_a.coh_bits[4 +: 2] !== 2'b01) begin
            errors++; $display("FAIL read after write: data=%h st=%b coh=%b want d2/11/01", bus_a.data_out[2*BW +: BW],
                               bus_a.status_bits[4 +: 2], bus_a.coh_bits[4 +: 2]);
        end
    endtask

    task automatic test_round_robin();
        int exp_v[4] = '{2, 2, 2, 3};
        for (int w = 0; w < NW; w++) step_b(1, 0, 1, 1, 22'h10 + TB'(w), w);
        step_b(0, 0, 1, 1, 22'h20, 0);
        step_b(0, 0, 1, 1, 22'h21, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) step_b(0, 0, 1, 1, 22'h23, 3);
            if (k == 2) step_b(1, 0, 1, 1, 22'h22, 2);
            if (k == 3) step_b(0, 0, 1, 1, 22'h32, 2);
            step_b(0, 1, 0, 1, 22'h3FFFFF, 0);
            checks++;
            if (bus_b.hit[0] !== 1'b0 || bus_b.matched_way[0 +: 2] !== WB'(exp_v[k])) begin
                errors++; $display("FAIL rr victim step%0d: hit=%b way=%0d want 0/%0d", k, bus_b.hit[0],
                                   bus_b.matched_way[0 +: 2], exp_v[k]);
            end
        end
    endtask

    task automatic test_random();
        int sets[4] = '{0, 1, 3, 255};
        for (int it = 0; it < 150; it++) begin
            clear_ops();
            for (int p = 0; p < NP; p++) begin
                int r = $urandom_range(0, 9);
                o_rd[p] = (r <= 3); o_wr[p] = (r >= 4 && r <= 6) || r == 8; o_inv[p] = (r == 7 || r == 8);
                o_idx[p] = sets[$urandom_range(0, 3)];
                o_way[p] = $urandom_range(0, NW - 1);
                o_tag[p] = 22'h000100 + TB'($urandom_range(0, 4));
                o_meta[p] = {($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom)};
                o_data[p] = {$urandom, $urandom, $urandom, $urandom};
            end
            step_a();
            for (int p = 0; p < NP; p++) begin
                if (o_rd[p]) begin
                    checks++;
                    if (bus_a.hit[p] !== e_hit[p] || bus_a.matched_way[p*WB +: WB] !== WB'(e_way[p])) begin
                        errors++; $display("FAIL rand it%0d p%0d hit/way: got %b/%0d want %b/%0d", it, p, bus_a.hit[p],
                                           bus_a.matched_way[p*WB +: WB], e_hit[p], e_way[p]);
                    end
                    checks++;
                    if (bus_a.tag_out[p*TB +: TB] !== e_tag[p] || bus_a.status_bits[p*2 +: 2] !== e_st[p] ||
                        bus_a.coh_bits[p*2 +: 2] !== e_co[p]) begin
                        errors++; $display("FAIL rand it%0d p%0d meta: got %h/%b/%b want %h/%b/%b", it, p,
                                           bus_a.tag_out[p*TB +: TB], bus_a.status_bits[p*2 +: 2], bus_a.coh_bits[p*2 +: 2],
                                           e_tag[p], e_st[p], e_co[p]);
                    end
                    if (e_dk[p]) begin
                        checks++;
                        if (bus_a.data_out[p*BW +: BW] !== e_data[p]) begin
                            errors++; $display("FAIL rand it%0d p%0d data: got %h want %h", it, p,
                                               bus_a.data_out[p*BW +: BW], e_data[p]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bus_a.read = '0; bus_a.write = '0; bus_a.invalidate = '0; bus_a.index = '0; bus_a.tag = '0;
        bus_a.meta_data = '0; bus_a.data_in = '0; bus_a.way_select = '0;
        bus_b.read = '0; bus_b.write = '0; bus_b.invalidate = '0; bus_b.index = '0; bus_b.tag = '0;
        bus_b.meta_data = '0; bus_b.data_in = '0; bus_b.way_select = '0;
        clear_ops();
        test_reset();
        test_post_init_read();
        test_write_read();
        test_lru_victim();
        test_invalidate();
        test_multi_write();
        test_back_to_back();
        test_round_robin();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
